rule_pg_loader: RTL

Runtime configuration controller for the port_group rule-to-port-group table. It accepts 32-bit host configuration words and packs them into table entries. For each entry it closes the port_group metadata gate and waits for in-flight rule lookups to drain, since port A of the table serves both writes and lookups. It then issues a single write pulse on the port_group memory write port and reopens the gate. It sits between the host config path and port_group, and inline on the port_group metadata handshake.

---
 rtl/rule_pg_loader_pkg.sv | 28 ++
 rtl/rule_pg_word_packer.sv | 90 +++++++++
 rtl/rule_pg_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rule_pg_loader_pkg.sv
// ---------------------------------------------------------------------------
// rule_pg_loader_pkg
//   Shared definitions for the port_group rule table loader.
//   - Table geometry defaults (RULE_PG_WIDTH, RULE_AWIDTH) and the host
//     config word width.
//   - loader_state_t: top-level loader FSM states.
//   - words_for(): number of 32-bit config words per table entry.
// ---------------------------------------------------------------------------
package rule_pg_loader_pkg;

  localparam int RULE_PG_WIDTH  = 32;
  localparam int RULE_AWIDTH    = 13;
  localparam int CFG_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_WAIT_GATE = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WRITE     = 3'd4
  } loader_state_t;

  // Config words needed to cover one entry (ceiling division).
  function automatic int words_for(input int entry_width);
    return (entry_width + CFG_WORD_WIDTH - 1) / CFG_WORD_WIDTH;
  endfunction

endpackage

// File: rtl/rule_pg_word_packer.sv
// ---------------------------------------------------------------------------
// rule_pg_word_packer
//   Packs accepted 32-bit config words into one table entry.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     i_accept      a config word is accepted this cycle (valid & ready)
//     i_data        config word; word i lands in entry bits [32i+31:32i]
//     i_addr        entry address, captured with the first word only
//     i_last        final word of the entry
//     o_entry       staged entry including this cycle's word (next value)
//     o_addr        staged address including this cycle's capture
//     o_err         sticky: some entry had a word count other than WORDS
// ---------------------------------------------------------------------------
module rule_pg_word_packer
  import rule_pg_loader_pkg::*;
#(
  parameter int ENTRY_WIDTH = 2*RULE_PG_WIDTH,
  parameter int ADDR_WIDTH  = RULE_AWIDTH-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_accept,
  input  logic [CFG_WORD_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic                      i_last,
  output logic [ENTRY_WIDTH-1:0]    o_entry,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic                      o_err
);

  localparam int WORDS   = words_for(ENTRY_WIDTH);
  localparam int STAGE_W = WORDS * CFG_WORD_WIDTH;
  // One extra code above WORDS marks "too many words" without wrapping.
  localparam int IDX_W   = $clog2(WORDS + 2);
  localparam logic [IDX_W-1:0] WORDS_C = IDX_W'(WORDS);
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(WORDS + 1);

  logic [STAGE_W-1:0]    r_stage;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;

  logic [STAGE_W-1:0]    w_stage_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [IDX_W-1:0]      w_count;

  assign w_count = (r_idx == IDX_SAT) ? r_idx : r_idx + IDX_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path holds state (no latch).
    w_stage_next = r_stage;
    w_addr_next  = r_addr;
    if (i_accept) begin
      // First word of an entry: clear stale bits so short entries read as zero.
      if (r_idx == '0) begin
        w_stage_next = '0;
        w_addr_next  = i_addr;
      end
      if (r_idx < WORDS_C) begin
        w_stage_next[int'(r_idx)*CFG_WORD_WIDTH +: CFG_WORD_WIDTH] = i_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_stage <= w_stage_next;
      r_addr  <= w_addr_next;
      if (i_accept) begin
        if (i_last) begin
          r_idx <= '0;
          if (w_count != WORDS_C) r_err <= 1'b1;
        end else begin
          r_idx <= w_count;
        end
      end
    end
  end

  assign o_entry = w_stage_next[ENTRY_WIDTH-1:0];
  assign o_addr  = w_addr_next;
  assign o_err   = r_err;

endmodule

// File: rtl/rule_pg_loader.sv
// ---------------------------------------------------------------------------
// rule_pg_loader
//   Runtime loader for the port_group rule-to-port-group table. Collects host
//   config words into entries, closes the metadata gate, waits for in-flight
//   lookups to drain, then issues one table write and reopens the gate.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     cfg_valid/ready/data/addr/last   host config word stream
//     up_meta_valid/up_meta_ready      metadata handshake from the parser
//     dn_meta_valid/dn_meta_ready      metadata handshake to port_group
//     wr_en/wr_addr/wr_data            registered table write port
//     cfg_err                    sticky bad-word-count flag
//     upd_cnt                    entries written (wraps)
//     stall_cnt                  cycles of pending metadata behind a closed gate
// ---------------------------------------------------------------------------
module rule_pg_loader
  import rule_pg_loader_pkg::*;
#(
  parameter int ENTRY_WIDTH  = 2*RULE_PG_WIDTH,
  parameter int ADDR_WIDTH   = RULE_AWIDTH-1,
  parameter int DRAIN_CYCLES = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_WORD_WIDTH-1:0] cfg_data,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr,
  input  logic                      cfg_last,
  input  logic                      up_meta_valid,
  output logic                      up_meta_ready,
  output logic                      dn_meta_valid,
  input  logic                      dn_meta_ready,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [ENTRY_WIDTH-1:0]    wr_data,
  output logic                      cfg_err,
  output logic [31:0]               upd_cnt,
  output logic [31:0]               stall_cnt
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  loader_state_t         r_state;
  logic                  r_gate_open;
  logic                  r_held;
  logic [DCW-1:0]        r_drain_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ENTRY_WIDTH-1:0] r_wr_data;
  logic [31:0]           r_upd_cnt;
  logic [31:0]           r_stall_cnt;

  logic                   w_accept;
  logic [ENTRY_WIDTH-1:0] w_entry;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_err;

  assign cfg_ready     = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_accept      = cfg_valid && cfg_ready;
  assign dn_meta_valid = up_meta_valid && r_gate_open;
  assign up_meta_ready = dn_meta_ready && r_gate_open;

  rule_pg_word_packer #(
    .ENTRY_WIDTH (ENTRY_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_data   (cfg_data),
    .i_addr   (cfg_addr),
    .i_last   (cfg_last),
    .o_entry  (w_entry),
    .o_addr   (w_addr),
    .o_err    (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gate_open <= 1'b1;
      r_held      <= 1'b0;
      r_drain_cnt <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_upd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (up_meta_valid && !r_gate_open) r_stall_cnt <= r_stall_cnt + 32'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= cfg_last ? ST_WAIT_GATE : ST_COLLECT;
        end

        ST_COLLECT: begin
          if (w_accept && cfg_last) begin
            if (r_held) begin
              // Gate already closed and drained: write straight away. The
              // packer's next-value outputs already include this last word.
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr;
              r_wr_data <= w_entry;
            end else begin
              r_state <= ST_WAIT_GATE;
            end
          end
        end

        ST_WAIT_GATE: begin
          if (!r_gate_open) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_state     <= ST_DRAIN;
          end else if (!up_meta_valid || dn_meta_ready) begin
            // Close only between packets: either nothing is offered or the
            // pending metadata handshakes this very cycle.
            r_gate_open <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_data <= w_entry;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end

        ST_WRITE: begin
          r_upd_cnt <= r_upd_cnt + 32'd1;
          if (cfg_valid) begin
            // Another entry is queued: keep the gate closed and reuse the drain.
            r_held  <= 1'b1;
            r_state <= ST_COLLECT;
          end else begin
            r_held      <= 1'b0;
            r_gate_open <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cfg_err   = w_err;
  assign upd_cnt   = r_upd_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
